// File: rtl/jesd204_rx_lane.sv
// jesd204_rx_lane: per-lane JESD204B receive link layer.
// Code-group sync drives the lane SYNC_n request. The ILA start /R/ fixes the
// word alignment. ILA multiframes are counted before aligned user data is
// streamed, and a saturating counter tracks cycles with 8b10b decode errors.
module jesd204_rx_lane #(
  parameter int ERR_THRESH = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 EN,
  input  logic [3:0][7:0]      DI,
  input  logic [3:0]           DI_K,
  input  logic [3:0]           DI_ERR,
  input  logic [7:0]           NUM_ILAS,
  input  logic                 CLR_ERR,
  output logic                 SYNC_REQ_n,
  output logic                 CGS_DONE,
  output logic                 ILA_DONE,
  output logic [1:0]           ALIGN,
  output logic [3:0][7:0]      DO,
  output logic [3:0]           DO_K,
  output logic                 DO_VALID,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [7:0] K_CHAR    = 8'hBC;
  localparam logic [7:0] R_CHAR    = 8'h1C;
  localparam logic [7:0] A_CHAR    = 8'h7C;
  localparam int         ERR_RUN_W = $clog2(ERR_THRESH + 1);

  typedef enum logic [1:0] {ST_INIT, ST_CGS, ST_ILA, ST_DATA} state_t;

  state_t               state, state_nxt;
  logic [3:0][7:0]      prev_p0;
  logic [3:0]           prev_k_p0;
  logic [3:0][7:0]      al_d;
  logic [3:0]           al_k;
  logic [2:0]           k_run, k_run_nxt;
  logic                 k_run_hit;
  logic                 nk_found, nk_is_r;
  logic [1:0]           nk_pos;
  logic                 err_any, err_trip, a_hit, ila_last;
  logic [ERR_RUN_W-1:0] err_run;
  logic [7:0]           ila_cnt, ila_need;

  function automatic logic is_char(input logic [7:0] d, input logic k, input logic [7:0] c);
    return k && (d == c);
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // Byte-rotating aligner: four consecutive octets starting at ALIGN within {DI, prev}
  always_comb begin
    case (ALIGN)
      2'd1:    begin al_d = {DI[0],   prev_p0[3:1]}; al_k = {DI_K[0],   prev_k_p0[3:1]}; end
      2'd2:    begin al_d = {DI[1:0], prev_p0[3:2]}; al_k = {DI_K[1:0], prev_k_p0[3:2]}; end
      2'd3:    begin al_d = {DI[2:0], prev_p0[3]};   al_k = {DI_K[2:0], prev_k_p0[3]};   end
      default: begin al_d = prev_p0;                 al_k = prev_k_p0;                 end
    endcase
  end

  // Link-state decode: /K/ run tracking, first non-/K/ search, error run and /A/ counting
  always_comb begin
    k_run_nxt = k_run;
    k_run_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (is_char(DI[i], DI_K[i], K_CHAR) && !DI_ERR[i])
        k_run_nxt = (k_run_nxt == 3'd4) ? 3'd4 : k_run_nxt + 3'd1;
      else
        k_run_nxt = 3'd0;
      if (k_run_nxt == 3'd4) k_run_hit = 1'b1;
    end
    nk_found = 1'b0;
    nk_is_r  = 1'b0;
    nk_pos   = 2'd0;
    // Scan downward so the lowest non-/K/ position wins
    for (int i = 3; i >= 0; i--) begin
      if (!is_char(DI[i], DI_K[i], K_CHAR)) begin
        nk_found = 1'b1;
        nk_is_r  = is_char(DI[i], DI_K[i], R_CHAR);
        nk_pos   = 2'(i);
      end
    end
    err_any   = |DI_ERR;
    err_trip  = err_any && (err_run == ERR_RUN_W'(ERR_THRESH - 1));
    ila_need  = (NUM_ILAS == 8'd0) ? 8'd1 : NUM_ILAS;
    a_hit     = is_char(al_d[3], al_k[3], A_CHAR);
    ila_last  = (ila_cnt + 8'd1) == ila_need;
    state_nxt = state;
    case (state)
      ST_INIT: if (k_run_hit) state_nxt = ST_CGS;
      ST_CGS: begin
        if (err_any || (nk_found && !nk_is_r)) state_nxt = ST_INIT;
        else if (nk_found)                     state_nxt = ST_ILA;
      end
      ST_ILA: begin
        if (err_trip)              state_nxt = ST_INIT;
        else if (a_hit && ila_last) state_nxt = ST_DATA;
      end
      default: if (err_trip) state_nxt = ST_INIT;
    endcase
    if (!EN) state_nxt = ST_INIT;
  end

  // Link FSM with registered status outputs; every status drops on the edge entering INIT
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= ST_INIT;
      k_run      <= 3'd0;
      err_run    <= '0;
      ila_cnt    <= 8'd0;
      ALIGN      <= 2'd0;
      SYNC_REQ_n <= 1'b0;
      CGS_DONE   <= 1'b0;
      ILA_DONE   <= 1'b0;
      DO_VALID   <= 1'b0;
    end else begin
      state      <= state_nxt;
      k_run      <= (state == ST_INIT && EN) ? k_run_nxt : 3'd0;
      err_run    <= ((state == ST_ILA || state == ST_DATA) && err_any && state_nxt != ST_INIT)
                    ? err_run + ERR_RUN_W'(1) : '0;
      ila_cnt    <= (state == ST_ILA && state_nxt == ST_ILA) ? ila_cnt + {7'd0, a_hit} : 8'd0;
      if (state == ST_CGS && state_nxt == ST_ILA) ALIGN <= nk_pos;
      SYNC_REQ_n <= (state_nxt != ST_INIT);
      CGS_DONE   <= (state_nxt != ST_INIT);
      ILA_DONE   <= (state_nxt == ST_DATA);
      DO_VALID   <= (state == ST_DATA) && (state_nxt == ST_DATA);
    end
  end

  // Stage p0: previous input word feeding the aligner
  always_ff @(posedge CLK) begin
    prev_p0   <= DI;
    prev_k_p0 <= DI_K;
  end

  // Stage p1: aligned output word, updated in every state
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      DO   <= '0;
      DO_K <= 4'd0;
    end else begin
      DO   <= al_d;
      DO_K <= al_k;
    end
  end

  // Saturating decode-error counter; clear takes priority over increment
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)       ERR_CNT <= '0;
    else if (CLR_ERR) ERR_CNT <= '0;
    else if (err_any) ERR_CNT <= sat_inc(ERR_CNT);
  end

endmodule
